// File: rtl/io_pkg.sv
// Shared definitions for the core's serial I/O blocks (TX buffer and RX side).
package io_pkg;

    // Serial frame FSM states; PARITY is only reached when UART_TX_PARITY_EN is defined
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // 100 MHz system clock at 115200 baud
    localparam int DEFAULT_CLK_PER_BIT = 868;

    // Payload bits per UART frame
    localparam int FRAME_DATA_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with active-low synchronous reset.
// rdata always shows the head entry; it is valid whenever empty is low.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_q;
    logic              push_ok;
    logic              pop_ok;

    // Full/empty come from the registered count, so a same-edge pop never admits a push at full
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign count   = count_q;

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)
                count_q <= count_q + 1'b1;
            else if (pop_ok && !push_ok)
                count_q <= count_q - 1'b1;
        end
    end

    // Storage array is data only and is never cleared
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_out_buffer.sv
// Output-port consumer: buffers core byte writes and sends them as UART frames.
// Default build is 8N1; define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
module uart_tx_out_buffer
    import io_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        out_issued,
    input  logic [31:0] out_data,
    output logic        out_stall,
    output logic        txd,
    output logic        tx_busy,
    output logic [31:0] sent_count
);

    localparam int BW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

    tx_state_t               state_q, state_d;
    logic [BW-1:0]           baud_q, baud_d;
    logic [2:0]              bit_q, bit_d;
    logic [FRAME_DATA_W-1:0] shift_q, shift_d;
    logic [31:0]             sent_q, sent_d;
    logic                    txd_q, txd_d;
    logic                    baud_end;
    logic                    pop;
    logic [FRAME_DATA_W-1:0] fifo_rdata;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  unused_fifo_count;
    logic [23:0]             unused_data_hi;

    // Only the low byte of a core write is ever transmitted
    assign unused_data_hi = out_data[31:8];

    sync_fifo #(
        .DATA_W (FRAME_DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (out_issued),
        .pop   (pop),
        .wdata (out_data[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

    assign baud_end   = (baud_q == BW'(CLK_PER_BIT - 1));
    assign out_stall  = fifo_full;
    assign tx_busy    = (state_q != IDLE) || !fifo_empty;
    assign txd        = txd_q;
    assign sent_count = sent_q;

    // Frame sequencing; txd is derived from the next state so the pin is a clean register
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        sent_d  = sent_q;
        pop     = 1'b0;
        txd_d   = 1'b1;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    sent_d = sent_q + 32'd1;
                    // Chain straight into the next frame so queued bytes go out with no gap
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = ^shift_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    // Control state and line register; reset forces the line idle on the next cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sent_q  <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sent_q  <= sent_d;
            txd_q   <= txd_d;
        end
    end

    // Shift register holds the byte in flight; data path carries no reset
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_uart_tx_out_buffer.sv
// Bench for uart_tx_out_buffer with CLK_PER_BIT=4, DEPTH=4. A line monitor
// decodes every frame on txd cycle by cycle against a queue of accepted bytes.
// Define UART_TX_PARITY_EN for both RTL and bench to cover the parity build.
module tb_uart_tx_out_buffer;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        out_issued = 1'b0;
    logic [31:0] out_data = '0;
    logic        out_stall;
    logic        txd;
    logic        tx_busy;
    logic [31:0] sent_count;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          sent_model = 0;
    int          last_push_cyc = 0;
    logic [7:0]  exp_q[$];
    int          start_q[$];
    logic [10:0] mon_frame;

    uart_tx_out_buffer #(
        .DEPTH       (DEPTH),
        .CLK_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .out_issued (out_issued),
        .out_data   (out_data),
        .out_stall  (out_stall),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Frame levels in line order: start, data LSB first, [parity], stop
    function automatic logic [10:0] make_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[1+i] = b[i];
            ones += int'(b[i]);
        end
`ifdef UART_TX_PARITY_EN
        f[9] = ((ones % 2) == 1);
`endif
        return f;
    endfunction

    // Line monitor: every cycle of a frame must show the expected level
    always begin
        @(negedge clk);
        if (rst && txd === 1'b0) begin
            chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                start_q.push_back(cyc);
                mon_frame = make_frame(exp_q.pop_front());
                for (int k = 0; k < FL; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!rst) break;
                    chk("txd", 32'(txd), 32'(mon_frame[k/CPB]));
                end
            end
        end
    end

    task automatic send(input logic [31:0] d);
        int w;
        w = 0;
        @(negedge clk);
        out_issued = 1'b1;
        out_data   = d;
        while (out_stall && w < 50 * FL) begin
            @(negedge clk);
            w++;
        end
        if (out_stall) begin
            chk("push_timeout", 32'(out_stall), 32'd0);
        end else begin
            exp_q.push_back(d[7:0]);
            sent_model++;
        end
        @(posedge clk);
        #1;
        last_push_cyc = cyc;
        out_issued = 1'b0;
        out_data   = $urandom;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (tx_busy && w < 20 * FL * (DEPTH + 2)) begin
            @(negedge clk);
            w++;
        end
        chk("idle_reached", 32'(tx_busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start(input int n);
        int w;
        w = 0;
        while (start_q.size() < n && w < 4 * FL) begin
            @(negedge clk);
            w++;
        end
        chk("start_seen", 32'(start_q.size() >= n), 32'd1);
    endtask

    task automatic wait_cyc(input int c);
        int w;
        w = 0;
        while (cyc != c && w < 4 * FL) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic check_gaps(input string tag, input int n);
        chk({tag, "_frames"}, start_q.size(), n);
        for (int i = 0; i + 1 < start_q.size(); i++)
            chk({tag, "_gap"}, start_q[i+1] - start_q[i], FL);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        int cE;
        int s;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_stall", 32'(out_stall), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_sent", sent_count, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte: latency, one IDLE cycle, full frame, counter
        start_q.delete();
        send(32'h0000_0055);
        cE = last_push_cyc;
        chk("busy_after_push", 32'(tx_busy), 32'd1);
        @(negedge clk);
        chk("idle_cycle_txd", 32'(txd), 32'd1);
        wait_idle();
        chk("single_frames", start_q.size(), 1);
        if (start_q.size() > 0) chk("latency", start_q[0], cE + 1);
        chk("sent_single", sent_count, sent_model);

        // Upper write bits are ignored
        send(32'hDEAD_BEA5);
        wait_idle();
        chk("sent_upper", sent_count, sent_model);

        // Fill and back-pressure, dropped writes while full, held write
        start_q.delete();
        for (int i = 1; i <= 5; i++) begin
            send(32'(i));
            if (i == 4) chk("stall_at_4", 32'(out_stall), 32'd0);
        end
        chk("stall_at_5", 32'(out_stall), 32'd1);
        @(negedge clk);
        out_issued = 1'b1;
        out_data   = 32'h0000_00EE;
        repeat (2) @(negedge clk);
        out_issued = 1'b0;
        chk("stall_hold", 32'(out_stall), 32'd1);
        send(32'h0000_0006);
        wait_idle();
        check_gaps("fill", 6);
        chk("sent_fill", sent_count, sent_model);

        // Push on the same edge as the STOP->START pop with two bytes queued
        start_q.delete();
        for (int i = 0; i < 3; i++) send(32'h0000_0030 + 32'(i));
        wait_start(1);
        s = (start_q.size() > 0) ? start_q[0] : cyc;
        wait_cyc(s + FL - 2);
        send(32'h0000_0040);
        chk("stall_sim_2", 32'(out_stall), 32'd0);
        send(32'h0000_0041);
        chk("stall_sim_3", 32'(out_stall), 32'd0);
        send(32'h0000_0042);
        chk("stall_sim_4", 32'(out_stall), 32'd1);
        wait_idle();
        check_gaps("sim", 6);
        chk("sent_sim", sent_count, sent_model);

        // Reset during data bit 3 with the FIFO full
        start_q.delete();
        for (int i = 0; i < 5; i++) send(32'h0000_00A3 + 32'(i));
        chk("stall_pre_rst", 32'(out_stall), 32'd1);
        wait_start(1);
        s = (start_q.size() > 0) ? start_q[0] : cyc;
        wait_cyc(s + CPB * 4 + 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_txd", 32'(txd), 32'd1);
        chk("mid_rst_busy", 32'(tx_busy), 32'd0);
        chk("mid_rst_sent", sent_count, 32'd0);
        chk("mid_rst_stall", 32'(out_stall), 32'd0);
        @(negedge clk);
        exp_q.delete();
        sent_model = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        start_q.delete();
        send(32'h0000_000F);
        wait_idle();
        chk("post_rst_frames", start_q.size(), 1);
        chk("post_rst_sent", sent_count, 32'd1);

`ifdef UART_TX_PARITY_EN
        // Parity build: odd and even population counts
        send(32'h0000_0007);
        wait_idle();
        send(32'h0000_0003);
        wait_idle();
        chk("sent_parity", sent_count, sent_model);
`endif

        // Randomised traffic with random gaps
        start_q.delete();
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, FL + 10)) @(negedge clk);
            send($urandom);
        end
        wait_idle();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_sent", sent_count, sent_model);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_out_buffer.md
Name: uart_tx_out_buffer

Overview:
- Downstream consumer of the core's output-I/O port.
- Accepts byte writes signalled by out_issued/out_data, buffers them in a FIFO, and serialises them on a UART TX line (8N1).
- Back-pressures the core through out_stall when the FIFO is full.
- Sits between the pipeline core and the board TX pin, alongside the input-side receiver.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- CLK_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- out_issued  input  1  core write strobe, one byte per asserted cycle.
- out_data  input  32  write data; only [7:0] transmitted, [31:8] ignored.
- out_stall  output  1  FIFO full; core must hold out_issued/out_data while high.
- txd  output  1  UART serial out, registered, idle high.
- tx_busy  output  1  high while FIFO non-empty or a frame is in flight.
- sent_count  output  32  bytes fully transmitted since reset.

Behaviour:
- Reset (rst==0 at a clk edge):
  - FIFO emptied; state=IDLE; txd=1; out_stall=0; tx_busy=0; sent_count=0.
  - Mid-frame reset truncates the frame; txd is 1 from the next cycle.
- Push: accepted iff out_issued && !out_stall at an edge.
  - out_stall = (count==DEPTH), driven from the registered count; no write-through bypass.
  - Write while full is dropped, and out_issued is not latched.
  - Push and pop in the same edge: both occur, count unchanged.
  - At full, a same-edge pop does not admit the push.
- Pointers: log2(DEPTH)-bit read/write pointers, wrapping mod DEPTH. count is 0..DEPTH, held in log2(DEPTH)+1 bits.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If count!=0, pop the head byte into shift_reg and go to START.
  - START: txd=0 for CLK_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: txd=shift_reg[bit_idx], LSB first, each bit CLK_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: txd=1 for CLK_PER_BIT cycles. On the final cycle: sent_count += 1 (wraps at 2^32). Then if count!=0, pop and go directly to START; else go to IDLE.
- Baud counter: 0..CLK_PER_BIT-1; reset to 0 on every state/bit transition.
- Latency: a byte pushed at edge E into an empty FIFO with FSM IDLE gives txd=0 from the cycle after edge E+1 (2 edges).
- Frame timing:
  - Frame = 10*CLK_PER_BIT cycles.
  - Back-to-back frames have no idle gap.
  - The first frame after IDLE incurs one IDLE cycle.
- tx_busy = (state!=IDLE) || (count!=0).

Optional Feature:
- Macro UART_TX_PARITY_EN.
  - Defined: adds state PARITY between DATA and STOP. txd = even parity (XOR of the 8 data bits) for CLK_PER_BIT cycles. Frame becomes 11*CLK_PER_BIT cycles.
  - Undefined: 8N1 as above; no PARITY state or logic present.

Decomposition:
- Shared package io_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Default CLK_PER_BIT constant.
  - Frame data width constant (8).
- One sub-module: sync_fifo.
  - Parameterised width/depth; push/pop/full/empty/count.
  - Synchronous active-low reset.
  - Reusable by the RX side.

Test Plan (CLK_PER_BIT=4, DEPTH=4):
- Single byte: push out_data=0x00000055 once → txd = 0, then 1,0,1,0,1,0,1,0, then 1, each level 4 cycles. Start bit begins 2 edges after push. sent_count 0→1 at stop end; tx_busy low after.
- Upper bits ignored: push 0xDEADBEA5 → transmitted bits are those of 0xA5 (LSB first 1,0,1,0,0,1,0,1).
- Fill/back-pressure: 5 consecutive pushes 0x01..0x05 with core honouring out_stall.
  - First byte pops at once, so out_stall rises after the 5th push is accepted.
  - A 6th push 0x06 while stalled is held, not dropped, until the next pop.
  - Output order is 01..06 with frames back-to-back (40 cycles apart).
- Simultaneous push/pop: count=2, push on the same edge as the STOP→START pop → count stays 2; no byte lost or duplicated.
- Reset mid-frame: rst=0 during DATA bit 3 → next cycle txd=1, tx_busy=0, sent_count=0, out_stall=0. After release, a new push of 0x0F transmits cleanly.
- UART_TX_PARITY_EN defined: push 0x07 → parity bit 1, frame 44 cycles. Push 0x03 → parity bit 0.
